// File: rtl/esm_pkg.sv
// Shared types and constants for the ESM issue scheduler.
package esm_pkg;

  localparam int REG_BITS = 5;
  localparam int NUM_REGS = 32;
  localparam int RD_LSB   = 7;
  localparam int RS1_LSB  = 15;
  localparam int RS2_LSB  = 20;

  // Entries store the word zero-extended to this width so one struct
  // serves every XLEN up to 64; unused upper bits are constant and trim away.
  localparam int XLEN_MAX = 64;

  typedef struct packed {
    logic [XLEN_MAX-1:0] instr;
    logic                reg_write;
    logic                alu_src;
    logic                valid;
  } entry_t;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/esm_scheduler_if.sv
// Instruction, issue and completion handshakes of the scheduler.
interface esm_scheduler_if import esm_pkg::*; #(
  parameter int XLEN = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     in_instr;
  logic                in_reg_write;
  logic                in_alu_src;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_instr;
  logic                cpl_valid;
  logic [REG_BITS-1:0] cpl_rd;

  modport master (
    output in_valid, in_instr, in_reg_write, in_alu_src, out_ready, cpl_valid, cpl_rd,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, in_instr, in_reg_write, in_alu_src, out_ready, cpl_valid, cpl_rd,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/esm_hazard_check.sv
// Per-slot hazard test: RAW/WAW against older writers and in-flight
// writers, WAR against older readers. x0 never creates a hazard.
module esm_hazard_check import esm_pkg::*; (
  input  entry_t              ent,
  input  logic [NUM_REGS-1:0] wr_mask,
  input  logic [NUM_REGS-1:0] rd_mask,
  input  logic [NUM_REGS-1:0] pending,
  output logic                eligible
);
  logic [REG_BITS-1:0] rd, rs1, rs2;
  logic [NUM_REGS-1:0] busy;
  logic                raw, waw, war;
  logic                unused_bits;

  assign rd   = ent.instr[RD_LSB  +: REG_BITS];
  assign rs1  = ent.instr[RS1_LSB +: REG_BITS];
  assign rs2  = ent.instr[RS2_LSB +: REG_BITS];
  // A register is busy if an older queued writer or an issued writer owns it.
  assign busy = wr_mask | pending;

  // Combine the three blocking conditions into the eligible bit.
  always_comb begin
    raw = (rs1 != '0) && busy[rs1];
    if (!ent.alu_src && (rs2 != '0) && busy[rs2]) raw = 1'b1;
    waw = ent.reg_write && (rd != '0) && busy[rd];
    war = ent.reg_write && (rd != '0) && rd_mask[rd];
    eligible = ent.valid && !raw && !waw && !war;
  end

  assign unused_bits = ^{ent.instr[XLEN_MAX-1:RS2_LSB+REG_BITS],
                         ent.instr[RS1_LSB-1:RD_LSB+REG_BITS],
                         ent.instr[RD_LSB-1:0]};
endmodule

// File: rtl/esm_scheduler.sv
// Age-ordered collapsing issue buffer with register scoreboard and a
// registered output slot. Slot 0 is always the oldest entry.
module esm_scheduler import esm_pkg::*; #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 16,
  parameter  int OOO   = 1,
  localparam int CW    = cnt_w(DEPTH),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  esm_scheduler_if.slave      bus,
  output logic [CW-1:0]       count,
  output logic [NUM_REGS-1:0] pending
);
  entry_t [DEPTH-1:0]           slots, slots_nxt;
  logic [DEPTH:0][NUM_REGS-1:0] wr_pre, rd_pre;
  logic [DEPTH-1:0]             elig, cand;
  logic                         sel_hit;
  logic [IW-1:0]                sel_idx;
  entry_t                       sel_ent, new_ent;
  logic                         load_en, issue, accept;
  logic [CW-1:0]                wr_ptr, count_nxt;
  logic [NUM_REGS-1:0]          set_vec, clr_vec;
  logic                         unused_sink;

  // No bypass: a full buffer refuses even while it issues.
  assign bus.in_ready = ~rst & (count < CW'(DEPTH));

  // Running OR of write and read masks; element i covers slots older than i.
  always_comb begin
    wr_pre[0] = '0;
    rd_pre[0] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_pre[i+1] = wr_pre[i];
      rd_pre[i+1] = rd_pre[i];
      if (slots[i].valid) begin
        if (slots[i].reg_write) wr_pre[i+1][slots[i].instr[RD_LSB +: REG_BITS]] = 1'b1;
        rd_pre[i+1][slots[i].instr[RS1_LSB +: REG_BITS]] = 1'b1;
        if (!slots[i].alu_src) rd_pre[i+1][slots[i].instr[RS2_LSB +: REG_BITS]] = 1'b1;
      end
      wr_pre[i+1][0] = 1'b0;
      rd_pre[i+1][0] = 1'b0;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    esm_hazard_check u_hz (
      .ent      (slots[i]),
      .wr_mask  (wr_pre[i]),
      .rd_mask  (rd_pre[i]),
      .pending  (pending),
      .eligible (elig[i])
    );
  end

  // In-order mode only lets the head compete.
  assign cand = (OOO != 0) ? elig : {{(DEPTH-1){1'b0}}, elig[0]};

  // Lowest-index (oldest) eligible candidate wins.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    sel_ent = slots[0];
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_hit = 1'b1;
        sel_idx = IW'(i);
        sel_ent = slots[i];
      end
    end
  end

  assign load_en   = (~bus.out_valid | bus.out_ready) & ~flush;
  assign issue     = load_en & sel_hit;
  assign accept    = bus.in_valid & bus.in_ready & ~flush;
  assign wr_ptr    = count - CW'(issue);
  assign count_nxt = count + CW'(accept) - CW'(issue);

  // Build the entry written on enqueue.
  always_comb begin
    new_ent           = '0;
    new_ent.instr     = XLEN_MAX'(bus.in_instr);
    new_ent.reg_write = bus.in_reg_write;
    new_ent.alu_src   = bus.in_alu_src;
    new_ent.valid     = 1'b1;
  end

  // Collapse over the issued slot, then append at the compressed tail.
  always_comb begin
    slots_nxt = slots;
    if (issue) begin
      for (int i = 0; i < DEPTH-1; i++)
        if (i >= int'(sel_idx)) slots_nxt[i] = slots[i+1];
      slots_nxt[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (accept && (wr_ptr == CW'(i))) slots_nxt[i] = new_ent;
  end

  // Scoreboard set/clear vectors; x0 is never tracked.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue && sel_ent.reg_write) set_vec[sel_ent.instr[RD_LSB +: REG_BITS]] = 1'b1;
    if (bus.cpl_valid && !flush) clr_vec[bus.cpl_rd] = 1'b1;
    set_vec[0] = 1'b0;
    clr_vec[0] = 1'b0;
  end

  // Buffer and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slots <= '0;
      count <= '0;
    end else begin
      slots <= slots_nxt;
      count <= count_nxt;
    end
  end

  // Output slot: holds while stalled, reloads or drains when free.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (load_en) begin
      bus.out_valid <= sel_hit;
      if (sel_hit) bus.out_instr <= sel_ent.instr[XLEN-1:0];
    end
  end

  // Scoreboard update; a same-cycle set beats the clear.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_vec) | set_vec;
  end

  assign unused_sink = ^{sel_ent, wr_pre[DEPTH], rd_pre[DEPTH]};
endmodule

// File: doc/esm_scheduler.md
# esm_scheduler

Parametrised, dependency-aware instruction issue scheduler for the ESM datapath. Accepts decoded instructions through a valid/ready port into an age-ordered buffer of DEPTH entries and issues the oldest hazard-free entry (or only the head, in in-order mode) to a registered output slot. A register scoreboard tracks issued-but-uncompleted writers, cleared by a completion port from the execute stage.

## Interface
- XLEN, 32: instruction word width; rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- DEPTH, 16: buffer entries, ≥2, need not be a power of two.
- OOO, 1: 1 = oldest-eligible issue; 0 = strict in-order (head only).
- clk  in  1  single clock; everything on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of buffer and output slot.
- in_valid  in  1  instruction offered.
- in_ready  out  1  buffer can accept.
- in_instr  in  XLEN  instruction word.
- in_reg_write  in  1  instruction writes rd.
- in_alu_src  in  1  1 = immediate operand; rs2 not read.
- out_valid  out  1  output slot holds an instruction.
- out_ready  in  1  downstream takes it.
- out_instr  out  XLEN  issued instruction.
- cpl_valid  in  1  a writer completed.
- cpl_rd  in  5  completed destination register.
- count  out  $clog2(DEPTH+1)  occupied buffer entries.
- pending  out  32  scoreboard; bit r = writer of xr in flight.

## Operation
- Buffer is a collapsing queue: slot 0 oldest; removal shifts younger entries down one; enqueue writes slot `count` after compression.
- in_ready = ~rst & (count < DEPTH); no bypass when full, even if issuing that cycle.
- Entry i is eligible iff valid and, ignoring x0 in every comparison:
  - RAW: rs1, or rs2 when !alu_src, matches rd of an older reg_write entry, or has its pending bit set -> blocked.
  - WAW: reg_write and rd matches an older reg_write entry, or pending[rd] -> blocked.
  - WAR: reg_write and rd matches rs1/rs2 read by an older entry -> blocked.
- OOO=0: only slot 0 is a candidate.
- Output slot load: when slot empty or (out_valid & out_ready), the lowest-index eligible entry moves into the slot and leaves the buffer; if none, out_valid falls.
- Slot contents are stable while out_valid & !out_ready.
- On load of a reg_write entry with rd≠0, set pending[rd]. cpl_valid clears pending[cpl_rd]; cpl_rd = 0 ignored. Set and clear of the same bit in one cycle: set wins.
- flush: count→0, out_valid→0; pending untouched; in_valid ignored that cycle.
- Enqueue and issue may occur in the same cycle; count changes by +1, 0 or -1 accordingly.

## Timing
- Reset values: count 0, out_valid 0, out_instr 0, pending 0, all entries invalid; in_ready 0 during rst, 1 the cycle after.
- Latency: accept in cycle t -> earliest out_valid in cycle t+2.
- Completion in cycle t -> dependent entry eligible for selection in cycle t+1 (out_valid t+2).
- Back-to-back independent instructions issue one per cycle at sustained throughput with out_ready held high.
- rst or flush mid-handshake: the pending transfer is dropped; no partial state.

## Structure
- esm_pkg: field-slice localparams (RD_LSB, RS1_LSB, RS2_LSB, REG_BITS = 5), entry struct {instr, reg_write, alu_src, valid}, count-width function.
- Sub-module esm_hazard_check: one instance per slot; inputs are the slot, the OR-reduced older-entry write/read masks and pending; output is the eligible bit.
- Priority select and the collapsing shift stay in esm_scheduler.

## Test plan
- Reset then 16 independent ADDI (distinct rd, x0 sources) with out_ready=1 -> out_valid cycle 2, one issue per cycle, in order, count peaks ≤2.
- ADD x5,x1,x2 then ADD x6,x5,x3 then ADDI x7,x0,1, OOO=1, no completion -> x5 op and x7 op issue, x6 op held; cpl_rd=5 -> x6 op on out_* two cycles later. OOO=0 -> x7 op waits behind x6 op.
- Fill 16 entries with out_ready=0 -> in_ready=0 at count=16; one out_ready pulse -> in_ready=1 next cycle, count=15.
- WAR: ADD x4,x9,x0 stalled behind pending x9, then ADDI x9,x0,3 -> younger must not issue ahead of older.
- cpl_valid for x8 in the same cycle a new x8 writer loads -> pending[8] stays 1.
- flush with 5 entries and out_valid=1 -> next cycle count=0, out_valid=0, pending unchanged; rst mid-stream -> all reset values.
